// File: rtl/alu_uart_pkg.sv
// Shared types and ALU opcode values for the UART <-> ALU glue logic.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EVAL,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/alu_uart_interface.sv
// Collects A, B and opcode bytes from the UART receiver, feeds them to the ALU and hands the
// captured result to the UART transmitter with a start/done handshake.
module alu_uart_interface
  import alu_uart_pkg::*;
#(
  parameter int unsigned NB_DATA     = 8,
  parameter int unsigned NB_OPERADOR = 6,
  parameter int unsigned NB_UART     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_UART-1:0]     i_rx_data,
  input  logic                   i_rx_done,
  input  logic                   i_tx_done,
  input  logic [NB_DATA-1:0]     i_resultado,
  output logic [NB_DATA-1:0]     o_dato_a,
  output logic [NB_DATA-1:0]     o_dato_b,
  output logic [NB_OPERADOR-1:0] o_operador,
  output logic [NB_UART-1:0]     o_tx_data,
  output logic                   o_tx_start,
  output logic                   o_busy,
  output logic                   o_error
);

  state_t                 state_q, state_d;
  logic [NB_DATA-1:0]     dato_a_q, dato_a_d;
  logic [NB_DATA-1:0]     dato_b_q, dato_b_d;
  logic [NB_OPERADOR-1:0] operador_q, operador_d;
  logic [NB_UART-1:0]     tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   error_q, error_d;
  logic                   busy;

  assign busy = (state_q == EVAL) || (state_q == SEND) || (state_q == WAIT_TX);

  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    operador_d = operador_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    error_d    = error_q;

    unique case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data[NB_DATA-1:0];
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data[NB_DATA-1:0];
          state_d  = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          operador_d = i_rx_data[NB_OPERADOR-1:0];
          state_d    = EVAL;
        end
      end
      EVAL: begin
        tx_data_d  = NB_UART'(i_resultado);
        // Registered start, so the pulse lines up with the SEND state.
        tx_start_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase

    // A byte arriving while a result is in flight is lost, even if tx_done frees us this cycle.
    if (i_rx_done && busy) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      operador_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      operador_q <= operador_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      error_q    <= error_d;
    end
  end

  assign o_dato_a   = dato_a_q;
  assign o_dato_b   = dato_b_q;
  assign o_operador = operador_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy;
  assign o_error    = error_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: bench-side ALU, frame-level reference model checked every
// cycle, plus directed literal checks.
module tb_alu_uart_interface;
  import alu_uart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] resultado;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [5:0] operador;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_start = 0;
  int pulse_cyc = 0;
  int start_cyc = -100;

  alu_uart_interface #(
    .NB_DATA    (8),
    .NB_OPERADOR(6),
    .NB_UART    (8)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_done  (rx_done),
    .i_tx_done  (tx_done),
    .i_resultado(resultado),
    .o_dato_a   (dato_a),
    .o_dato_b   (dato_b),
    .o_operador (operador),
    .o_tx_data  (tx_data),
    .o_tx_start (tx_start),
    .o_busy     (busy),
    .o_error    (error)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      ADD:     alu_f = a + b;
      SUB:     alu_f = a - b;
      AND:     alu_f = a & b;
      OR:      alu_f = a | b;
      XOR:     alu_f = a ^ b;
      NOR:     alu_f = ~(a | b);
      SRA:     alu_f = 8'($signed(a) >>> b);
      SRL:     alu_f = a >> b;
      default: alu_f = 8'h00;
    endcase
  endfunction

  assign resultado = alu_f(dato_a, dato_b, operador);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: bytes fill A, B, opcode in order; a completed frame makes the block
  // busy, the result is captured one edge later, start follows, and tx_done frees it only
  // once the transmitter handshake has actually begun (third edge onward).
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       m_err, m_busy, m_start;
  int         m_nbytes, m_since;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
      m_err = 0; m_busy = 0; m_start = 0;
      m_nbytes = 0; m_since = 0;
    end else begin
      m_start = 0;
      if (m_busy) begin
        m_since++;
        if (rx_done) m_err = 1;
        if (m_since == 1) begin
          m_tx    = alu_f(m_a, m_b, m_op);
          m_start = 1;
        end
        if (m_since >= 3 && tx_done) m_busy = 0;
      end else if (rx_done) begin
        case (m_nbytes)
          0:       m_a  = rx_data;
          1:       m_b  = rx_data;
          default: m_op = rx_data[5:0];
        endcase
        if (m_nbytes == 2) begin
          m_nbytes = 0;
          m_busy   = 1;
          m_since  = 0;
        end else begin
          m_nbytes++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_dato_a", dato_a, m_a);
      chk("cyc_dato_b", dato_b, m_b);
      chk("cyc_operador", operador, m_op);
      chk("cyc_tx_data", tx_data, m_tx);
      chk("cyc_tx_start", tx_start, m_start);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_error", error, m_err);
      if (tx_start) begin
        n_start++;
        start_cyc = cyc;
      end
    end
  end

  task automatic rx(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data   = b;
    rx_done   = 1'b1;
    pulse_cyc = cyc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic txd();
    @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
  endtask

  task automatic rx_and_txd(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dato_a"}, dato_a, 0);
    chk({tag, "_dato_b"}, dato_b, 0);
    chk({tag, "_operador"}, operador, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ADD 5 + 10
    n_start = 0;
    rx(8'h05); rx(8'h0A); rx(8'h20);
    idle(4);
    chk("add_a", dato_a, 8'h05);
    chk("add_b", dato_b, 8'h0A);
    chk("add_op", operador, 6'h20);
    chk("add_tx", tx_data, 8'h0F);
    chk("add_starts", n_start, 1);
    chk("add_latency", start_cyc - pulse_cyc, 2);
    chk("add_busy", busy, 1);
    txd();
    chk("add_idle_busy", busy, 0);

    // SUB wraps, then SRA with opcode upper bits dropped
    rx(8'h06); rx(8'h07); rx(8'h22);
    idle(4);
    chk("sub_tx", tx_data, 8'hFF);
    txd();
    rx(8'h16); rx(8'h03); rx(8'hC3);
    idle(4);
    chk("sra_op", operador, 6'h03);
    chk("sra_tx", tx_data, 8'h02);

    // Byte during WAIT_TX is dropped and flagged
    rx(8'h05);
    chk("drop_err", error, 1);
    chk("drop_a", dato_a, 8'h16);
    txd();
    rx(8'h01); rx(8'h01); rx(8'h20);
    idle(4);
    chk("after_drop_tx", tx_data, 8'h02);
    chk("after_drop_err", error, 1);

    // rx and tx_done together in WAIT_TX: back to WAIT_A, byte lost
    rx_and_txd(8'h33);
    chk("both_busy", busy, 0);
    chk("both_a", dato_a, 8'h01);
    chk("both_err", error, 1);

    // Asynchronous reset mid-frame
    rx(8'h05); rx(8'h0A);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_start = 0;
    rx(8'h01); rx(8'h02); rx(8'h25);
    idle(4);
    chk("or_a", dato_a, 8'h01);
    chk("or_tx", tx_data, 8'h03);
    chk("or_err", error, 0);

    // No tx_done for a long time: single start pulse, stays busy
    idle(1000);
    chk("hold_starts", n_start, 1);
    chk("hold_busy", busy, 1);
    txd();
    idle(2);
    chk("hold_release_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
